// File: rtl/sl2_aggr.sv
// -----------------------------------------------------------------------------
// sl2_aggr
//   Jump-target former for J-type instructions. The 26-bit instruction index is
//   shifted left by two and combined with the region bits (top four bits) of the
//   PC of the following instruction. There is no adder. Bits are only
//   concatenated, so the result cannot carry or wrap.
//
// Ports
//   clk            in   1   clock, rising edge
//   rst            in   1   synchronous reset, active low
//   in_valid       in   1   qualifies in_addr/in_pc for registered capture
//   in_addr        in   26  instruction index field (instr[25:0])
//   in_pc          in   32  PC+4, supplies region bits [31:28]
//   y              out  32  combinational jump target
//   y_reg          out  32  registered jump target
//   out_valid      out  1   y_reg was captured on the previous edge
//   pc_misaligned  out  1   combinational, in_pc[1:0] != 0
// -----------------------------------------------------------------------------
module sl2_aggr #(
    parameter int ADDR_W = 26,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [PC_W-1:0]   in_pc,
    output logic [PC_W-1:0]   y,
    output logic [PC_W-1:0]   y_reg,
    output logic              out_valid,
    output logic              pc_misaligned
);

    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] y_q, y_d;
    logic            vld_q, vld_d;

    // Region bits, then the index, then two zero bits for word alignment.
    // in_pc[27:0] has no path to the target.
    assign tgt           = {in_pc[PC_W-1:PC_W-4], in_addr, 2'b00};
    assign y             = tgt;
    assign pc_misaligned = in_pc[1] | in_pc[0];

    // Capture is independent of pc_misaligned. The flag is advisory only.
    always_comb begin
        y_d   = y_q;
        vld_d = 1'b0;
        if (in_valid) begin
            y_d   = tgt;
            vld_d = 1'b1;
        end
    end

    // Reset takes priority over in_valid, so a capture pending on that edge
    // is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            y_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            y_q   <= y_d;
            vld_q <= vld_d;
        end
    end

    assign y_reg     = y_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_sl2_aggr.sv
module tb_sl2_aggr;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [25:0] in_addr;
    logic [31:0] in_pc;
    logic [31:0] y;
    logic [31:0] y_reg;
    logic        out_valid;
    logic        pc_misaligned;

    int vectors = 0;
    int errs    = 0;

    logic [31:0] sb_q[$];
    logic [31:0] hold_m;
    logic        ov_m;

    sl2_aggr dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_addr      (in_addr),
        .in_pc        (in_pc),
        .y            (y),
        .y_reg        (y_reg),
        .out_valid    (out_valid),
        .pc_misaligned(pc_misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle. The expected target is queued when it is driven and
    // popped when out_valid shows it.
    task automatic step(input logic v, input logic r, input logic [25:0] a, input logic [31:0] p);
        logic [31:0] ey;
        logic [31:0] e;
        @(negedge clk);
        rst = r; in_valid = v; in_addr = a; in_pc = p;
        #1;
        ey = {p[31:28], a, 2'b00};
        chk("y_comb", y, ey);
        chk("pc_misaligned", {31'd0, pc_misaligned}, {31'd0, (p[1] | p[0])});
        if (!r) begin
            sb_q.delete();
            hold_m = 32'h0;
            ov_m   = 1'b0;
        end else if (v) begin
            sb_q.push_back(ey);
            ov_m = 1'b1;
        end else begin
            ov_m = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("y_after_edge", y, ey);
        chk("out_valid", {31'd0, out_valid}, {31'd0, ov_m});
        if (ov_m) begin
            if (sb_q.size() == 0) begin
                vectors++;
                errs++;
                $error("FAIL scoreboard_empty observed=empty expected=entry");
            end else begin
                e = sb_q.pop_front();
                hold_m = e;
                chk("y_reg", y_reg, e);
            end
        end else begin
            chk("y_reg_hold", y_reg, hold_m);
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_pc = '0;
        hold_m = 32'h0; ov_m = 1'b0;

        // Reset state. in_valid is high on the second cycle and must be overridden.
        step(1'b0, 1'b0, 26'h0, 32'h0);
        step(1'b1, 1'b0, 26'h2AA_AAAA, 32'h5000_0000);

        // Combinational vectors, with capture idle.
        step(1'b0, 1'b1, 26'h000_0001, 32'h0040_0004);
        step(1'b0, 1'b1, 26'h3FF_FFFF, 32'hF000_0000);
        step(1'b0, 1'b1, 26'h000_0000, 32'hA123_4567);
        // Low PC bits must not reach y.
        step(1'b0, 1'b1, 26'h155_5555, 32'h6FFF_FFFF);
        step(1'b0, 1'b1, 26'h155_5555, 32'h6000_0002);

        // Single capture, then an idle cycle that must hold y_reg.
        step(1'b1, 1'b1, 26'h010_0000, 32'h1000_0008);
        step(1'b0, 1'b1, 26'h000_0003, 32'h2000_0000);
        step(1'b0, 1'b1, 26'h000_0007, 32'h3000_0001);

        // Three captures back to back.
        step(1'b1, 1'b1, 26'h000_0010, 32'h4000_0004);
        step(1'b1, 1'b1, 26'h3FF_FFFF, 32'hF000_0000);
        step(1'b1, 1'b1, 26'h123_4567, 32'h8000_0003);
        step(1'b0, 1'b1, 26'h0, 32'h0);

        // Reset in the middle of a stream discards the capture.
        step(1'b1, 1'b1, 26'h0AB_CDEF, 32'h9000_0000);
        step(1'b1, 1'b0, 26'h0FE_DCBA, 32'hC000_0004);
        step(1'b0, 1'b1, 26'h011_1111, 32'hD000_0000);
        step(1'b1, 1'b1, 26'h022_2222, 32'hE000_0001);
        step(1'b0, 1'b1, 26'h0, 32'h0);

        // A few random vectors with mixed valid.
        for (int i = 0; i < 12; i++)
            step(1'($urandom_range(0, 1)), 1'b1, 26'($urandom), 32'($urandom));
        step(1'b0, 1'b1, 26'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sl2_aggr.md
SL2_AGGR -- requirements
Module: sl2_aggr

Interface
REQ-001 Parameter ADDR_W, default 26: jump-field width; fixed, other values unsupported.
REQ-002 Parameter PC_W, default 32: PC and output width; fixed, other values unsupported.
REQ-003 clk  input  1  clock; all registers update on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  qualifies in_addr/in_pc for registered capture.
REQ-006 in_addr  input  26  J-type instruction index field (instr[25:0]).
REQ-007 in_pc  input  32  PC of the following instruction (PC+4), supplies region bits.
REQ-008 y  output  32  combinational jump target.
REQ-009 y_reg  output  32  registered jump target.
REQ-010 out_valid  output  1  y_reg holds a target captured on the previous edge.
REQ-011 pc_misaligned  output  1  combinational, in_pc[1:0] != 2'b00.

Function
REQ-012 y SHALL equal {in_pc[31:28], in_addr[25:0], 2'b00} at all times, purely combinational, zero latency.
REQ-013 y SHALL be unaffected by rst and clk; X/Z-free inputs SHALL give an X-free y.
REQ-014 y[1:0] SHALL always be 2'b00; in_pc[27:0] SHALL NOT influence y.
REQ-015 On a rising edge with rst=1 and in_valid=1, y_reg SHALL load the REQ-012 value and out_valid SHALL be 1 in the next cycle.
REQ-016 On a rising edge with rst=1 and in_valid=0, y_reg SHALL hold its value and out_valid SHALL be 0 in the next cycle.
REQ-017 Latency in_valid -> out_valid SHALL be exactly one cycle; back-to-back in_valid SHALL yield back-to-back out_valid with each target in order; no backpressure.
REQ-018 pc_misaligned SHALL be (in_pc[1] | in_pc[0]), combinational; it SHALL NOT block y or capture.
REQ-019 No arithmetic is performed; there is no carry and no wrap-around; the all-ones field with in_pc[31:28]=4'hF SHALL give 32'hFFFF_FFFC.

Reset
REQ-020 A rising edge with rst=0 SHALL set y_reg to 32'h0000_0000 and out_valid to 0, overriding in_valid.
REQ-021 Reset asserted mid-stream SHALL discard any pending capture; the first out_valid after release SHALL follow the first in_valid sampled with rst=1.
REQ-022 Reset SHALL NOT affect y or pc_misaligned.

Verification
REQ-023 in_addr=26'h0000001, in_pc=32'h0040_0004 -> y=32'h0000_0004, pc_misaligned=0.
REQ-024 in_addr=26'h3FF_FFFF, in_pc=32'hF000_0000 -> y=32'hFFFF_FFFC.
REQ-025 in_addr=26'h000_0000, in_pc=32'hA123_4567 -> y=32'hA000_0000, pc_misaligned=1.
REQ-026 in_addr=26'h010_0000, in_pc=32'h1000_0008, in_valid=1 for one edge -> next cycle y_reg=32'h1040_0000, out_valid=1; following idle cycle out_valid=0, y_reg held.
REQ-027 Three consecutive in_valid cycles with distinct inputs -> three consecutive out_valid cycles, y_reg matching each REQ-012 value in order.
REQ-028 rst=0 on an edge with in_valid=1 -> next cycle y_reg=0, out_valid=0, y still equals the REQ-012 value of the current inputs.
